sram_bus_master: RTL and testbench
==================================

Name: sram_bus_master

Overview:
- Initiator for the synchronous chip-select SRAM bus: cs/we/oe controls, shared address and a bidirectional tri-state data bus.
- Converts a valid/ready command stream into single-beat or incrementing burst reads and writes.
- Streams write data in and read data out.
- Sits between datapath engines and any memory slave on this bus.

Parameters:
- DATA_WIDTH, 16, data bus and stream width.
- ADDR_WIDTH, 10, memory address width.
- LEN_WIDTH, 4, burst length field width; a burst is cmd_len+1 beats, max 2^LEN_WIDTH.

Ports:
- clk  in  1  bus and logic clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_we  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  first beat address.
- cmd_len  in  LEN_WIDTH  beats minus one.
- wr_valid  in  1  write beat data available.
- wr_ready  out  1  write beat consumed when wr_valid && wr_ready.
- wr_data  in  DATA_WIDTH  write beat data.
- rd_valid  out  1  one-cycle read beat strobe; no backpressure.
- rd_data  out  DATA_WIDTH  read beat data.
- rd_last  out  1  final beat of a read burst, qualified by rd_valid.
- busy  out  1  high whenever state != IDLE.
- mem_address  out  ADDR_WIDTH  bus address.
- mem_data  inout  DATA_WIDTH  driven only when mem_cs && mem_we; otherwise 'z.
- mem_cs  out  1  chip select.
- mem_we  out  1  write enable.
- mem_oe  out  1  output enable.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All bus controls and strobes are registered outputs; mem_data enable is derived from registered mem_cs && mem_we.
- Reset values:
  - State IDLE.
  - cmd_ready=0, wr_ready=0, rd_valid=0, rd_last=0, busy=0.
  - mem_cs=0, mem_we=0, mem_oe=0.
  - mem_address=0, rd_data=0, mem_data released.
  - cmd_ready rises the first cycle after reset deasserts.
- Reset mid-burst: bus released immediately (asynchronous), remaining beats discarded, no further rd_valid. The memory may have captured a partial write.
- States: IDLE, WRITE, READ, RD_DRAIN, TURN.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch addr, beat counter = cmd_len, and direction.
  - Go to WRITE (cmd_we=1) or READ.
- WRITE:
  - wr_ready=1.
  - Each cycle with wr_valid: drive mem_cs=1, mem_we=1, mem_oe=0, mem_address=current, mem_data=wr_data (registered), so the slave captures it at the next edge.
  - Cycle without wr_valid: mem_cs=0 (stall, no write).
  - After the last beat is accepted: go to IDLE. A following write may issue back-to-back.
- READ:
  - One address per cycle: mem_cs=1, mem_we=0, mem_oe=1, address incrementing.
  - After the last address is issued: go to RD_DRAIN. Hold mem_cs=1, mem_oe=1, address unchanged for one cycle.
- Read data capture:
  - The slave registers each address at the edge it is presented and drives the result during the following cycle.
  - The master samples mem_data at the end of that cycle and presents rd_data with rd_valid on the next cycle.
  - Read latency from first address cycle to first rd_valid: 2 cycles.
  - Beats return one per cycle, in order. rd_last accompanies beat cmd_len+1.
- RD_DRAIN -> TURN: one idle cycle with all controls 0 and the bus released, guaranteeing no contention. TURN -> IDLE.
- The command following a read therefore is accepted no earlier than 3 cycles after the last read address cycle.
- Address wrap: increment modulo 2^ADDR_WIDTH (address 2^ADDR_WIDTH-1 is followed by 0).
- Beat counter underflow is impossible; bursts of exactly 1 beat (cmd_len=0) must work in both directions.
- cmd_ready is 0 in every state except IDLE. A command asserted during a burst waits.

Test Plan:
- Reset 3 cycles then release -> all outputs 0, mem_data Z during reset; cmd_ready=1 on first post-reset cycle.
- Single write addr=0x005, data=0xBEEF, then single read addr=0x005 -> mem_cs&&mem_we one cycle with address 0x005; rd_valid=1, rd_last=1, rd_data=0xBEEF exactly 2 cycles after the read address cycle.
- 4-beat write at 0x3FE with data 0x1111..0x4444, wr_valid dropped for 2 cycles after beat 2 -> addresses 0x3FE, 0x3FF, 0x000, 0x001; mem_cs=0 during the stall; 4-beat read returns 0x1111..0x4444 on consecutive cycles, rd_last only on 0x4444.
- Read burst immediately followed by a queued write -> TURN cycle with mem_cs=0 and the bus released observed; master never drives while mem_oe=1 (contention check on mem_data X).
- Assert rst during beat 3 of an 8-beat read -> rd_valid stops at once, state IDLE, cmd_ready=1 after release; a new read returns correct data.
- Back-to-back single writes with cmd_valid held -> one write per IDLE+WRITE pair; busy drops only in IDLE.

Source files
------------

// File: rtl/sram_bus_master_if.sv
// sram_bus_master_if: command, write-stream, read-stream and SRAM control signals of the bus master.
// Signals: cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_len (command stream), wr_valid/wr_ready/wr_data
//   (write beats), rd_valid/rd_data/rd_last (read beats), busy, mem_address/mem_cs/mem_we/mem_oe.
// The tri-state data bus is a separate net on the master so it can be resolved against the slave.
interface sram_bus_master_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy,
               mem_address, mem_cs, mem_we, mem_oe
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy,
               mem_address, mem_cs, mem_we, mem_oe
    );
endinterface

// File: rtl/sram_bus_master.sv
// sram_bus_master: turns a valid/ready command stream into single or incrementing burst SRAM accesses.
// Ports: clk; rst (asynchronous, active-high); bus (master modport: command stream, write-beat stream,
//   read-beat stream, busy, registered mem_address/mem_cs/mem_we/mem_oe); mem_data (tri-state data bus,
//   driven only while the registered mem_cs && mem_we are high).
module sram_bus_master #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_bus_master_if.master     bus,
    inout  wire [DATA_WIDTH-1:0]  mem_data
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, RD_DRAIN, TURN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] nxt_q, nxt_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  cs_q, cs_d, we_q, we_d, oe_q, oe_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  cmd_ready_q, wr_ready_q;
    logic                  pend_q, pend_last_q, rd_valid_q, rd_last_q;
    logic                  cmd_hs, wr_hs;

    assign cmd_hs = bus.cmd_valid && cmd_ready_q;
    assign wr_hs  = bus.wr_valid && wr_ready_q;

    // addr_q is the address on the bus; nxt_q is the address the following beat will use.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        nxt_d   = nxt_q;
        cnt_d   = cnt_q;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        oe_d    = 1'b0;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (cmd_hs) begin
                cnt_d   = bus.cmd_len;
                state_d = bus.cmd_we ? WRITE : READ;
                nxt_d   = bus.cmd_we ? bus.cmd_addr : bus.cmd_addr + 1'b1;
                if (!bus.cmd_we) begin
                    // first read address goes out on the cycle READ is entered
                    addr_d = bus.cmd_addr;
                    cs_d   = 1'b1;
                    oe_d   = 1'b1;
                end
            end
            WRITE: if (wr_hs) begin
                cs_d    = 1'b1;
                we_d    = 1'b1;
                addr_d  = nxt_q;
                nxt_d   = nxt_q + 1'b1;
                wdata_d = bus.wr_data;
                if (cnt_q == '0) state_d = IDLE;
                else cnt_d = cnt_q - 1'b1;
            end
            READ: begin
                cs_d = 1'b1;
                oe_d = 1'b1;
                if (cnt_q == '0) state_d = RD_DRAIN;
                else begin
                    addr_d = nxt_q;
                    nxt_d  = nxt_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                end
            end
            RD_DRAIN: state_d = TURN;
            TURN:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            nxt_q       <= '0;
            cnt_q       <= '0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            nxt_q       <= nxt_d;
            cnt_q       <= cnt_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            wdata_q     <= wdata_d;
            cmd_ready_q <= state_d == IDLE;
            wr_ready_q  <= state_d == WRITE;
            // every READ cycle presents a real address; the slave answers in the next cycle,
            // which is when pend_q is high and the bus is sampled
            pend_q      <= state_q == READ;
            pend_last_q <= state_q == READ && cnt_q == '0;
            rd_valid_q  <= pend_q;
            rd_last_q   <= pend_last_q;
            if (pend_q) rdata_q <= mem_data;
        end
    end

    assign mem_data        = (cs_q && we_q) ? wdata_q : {DATA_WIDTH{1'bz}};
    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.wr_ready    = wr_ready_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rdata_q;
    assign bus.rd_last     = rd_last_q;
    assign bus.busy        = state_q != IDLE;
    assign bus.mem_address = addr_q;
    assign bus.mem_cs      = cs_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_oe      = oe_q;
endmodule

// File: tb/tb_sram_bus_master.sv
// tb_sram_bus_master: directed checks of sram_bus_master against a registered-read SRAM slave model.
module tb_sram_bus_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    wire [15:0] mem_data;

    sram_bus_master_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .LEN_WIDTH(4)) bus ();

    sram_bus_master #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .LEN_WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_data (mem_data)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [1024];
    logic [15:0] s_q;
    logic        s_drv = 1'b0;
    logic [9:0]  wlog_a [$];
    logic [15:0] wlog_d [$];
    logic [15:0] vec [8];
    int          conflicts = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    // slave: captures writes at the edge, registers read addresses and drives data the next cycle
    assign mem_data = s_drv ? s_q : 16'bz;

    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_we) begin
            mem[bus.mem_address] <= mem_data;
            wlog_a.push_back(bus.mem_address);
            wlog_d.push_back(mem_data);
        end
        s_drv <= bus.mem_cs && bus.mem_oe && !bus.mem_we;
        s_q   <= mem[bus.mem_address];
    end

    always @(negedge clk)
        if ((s_drv && bus.mem_cs && bus.mem_we) || (bus.mem_oe && bus.mem_we)) conflicts++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_cmd(input logic we, input logic [9:0] a, input logic [3:0] len);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = a;
        bus.cmd_len   = len;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", 32'(bus.cmd_ready), 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [9:0] a, input int n, input int stall_after);
        int base = wlog_a.size();
        logic [9:0] ea;
        send_cmd(1'b1, a, 4'(n - 1));
        for (int i = 0; i < n; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = vec[i];
            @(negedge clk);
            if (i == stall_after) begin
                bus.wr_valid = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    @(negedge clk);
                    chk("stall_cs", 32'(bus.mem_cs), 0);
                end
            end
        end
        bus.wr_valid = 1'b0;
        @(negedge clk);
        chk("wr_count", 32'(wlog_a.size() - base), 32'(n));
        for (int i = 0; i < n; i++)
            if (base + i < wlog_a.size()) begin
                ea = a + 10'(i);
                chk("wr_addr", 32'(wlog_a[base + i]), 32'(ea));
                chk("wr_data", 32'(wlog_d[base + i]), 32'(vec[i]));
            end
    endtask

    // called on the negedge inside the first address cycle of a read of n beats
    task automatic check_beats(input logic [9:0] a, input int n);
        logic [9:0] a1 = a + 10'd1;
        chk("rd_addr0", 32'(bus.mem_address), 32'(a));
        chk("rd_ctl0", 32'({bus.mem_cs, bus.mem_we, bus.mem_oe}), 32'h5);
        @(negedge clk);
        if (n > 1) chk("rd_addr1", 32'(bus.mem_address), 32'(a1));
        chk("rd_early", 32'(bus.rd_valid), 0);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            chk("rd_valid", 32'(bus.rd_valid), 1);
            chk("rd_data", 32'(bus.rd_data), 32'(vec[i]));
            chk("rd_last", 32'(bus.rd_last), 32'(i == n - 1));
            if (i == n - 1)
                chk("turn_ctl", 32'({bus.mem_cs, bus.mem_we, bus.mem_oe, bus.cmd_ready}), 0);
            @(negedge clk);
        end
        chk("rd_idle", 32'({bus.rd_valid, bus.cmd_ready}), 32'h1);
    endtask

    task automatic read_burst(input logic [9:0] a, input int n);
        send_cmd(1'b0, a, 4'(n - 1));
        check_beats(a, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", 32'({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.busy,
                            bus.mem_cs, bus.mem_we, bus.mem_oe}), 0);
        chk("rst_addr", 32'(bus.mem_address), 0);
        chk("rst_rdata", 32'(bus.rd_data), 0);
        rst = 1'b0;
        #1 chk("rel_ready", 32'(bus.cmd_ready), 0);
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.cmd_ready), 1);

        vec[0] = 16'hBEEF;
        write_burst(10'h005, 1, -1);
        read_burst(10'h005, 1);

        vec[0] = 16'h1111; vec[1] = 16'h2222; vec[2] = 16'h3333; vec[3] = 16'h4444;
        write_burst(10'h3FE, 4, 1);
        read_burst(10'h3FE, 4);

        send_cmd(1'b0, 10'h3FE, 4'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b1;
        bus.cmd_addr  = 10'h010;
        bus.cmd_len   = 4'd0;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 16'hCAFE;
        check_beats(10'h3FE, 2);
        @(negedge clk);
        chk("q_wr_ready", 32'(bus.wr_ready), 1);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("q_wr_ctl", 32'({bus.mem_cs, bus.mem_we, bus.mem_oe}), 32'h6);
        chk("q_wr_addr", 32'(bus.mem_address), 32'h010);
        bus.wr_valid = 1'b0;
        @(negedge clk);
        chk("q_wr_log", 32'({wlog_a[wlog_a.size() - 1], wlog_d[wlog_d.size() - 1]}), 32'h010CAFE);

        for (int i = 0; i < 8; i++) vec[i] = 16'hA000 + 16'(i);
        write_burst(10'h100, 8, -1);
        send_cmd(1'b0, 10'h100, 4'd7);
        repeat (2) @(negedge clk);
        chk("rr_b1", 32'({bus.rd_valid, bus.rd_data}), 32'h1A000);
        @(negedge clk);
        chk("rr_b2", 32'({bus.rd_valid, bus.rd_data}), 32'h1A001);
        @(negedge clk);
        chk("rr_b3", 32'({bus.rd_valid, bus.rd_data}), 32'h1A002);
        rst = 1'b1;
        #1 chk("rr_rst_out", 32'({bus.rd_valid, bus.mem_cs, bus.mem_oe, bus.busy, bus.cmd_ready}), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rr_rst_rdv", 32'(bus.rd_valid), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rr_rel", 32'({bus.cmd_ready, bus.busy, bus.rd_valid}), 32'h4);
        vec[0] = 16'hA004; vec[1] = 16'hA005;
        read_burst(10'h104, 2);

        bus.wr_valid = 1'b1;
        bus.cmd_we   = 1'b1;
        bus.cmd_len  = 4'd0;
        for (int k = 0; k < 3; k++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_addr  = 10'h020 + 10'(k);
            bus.wr_data   = 16'h5550 + 16'(k);
            chk("b2b_busy_idle", 32'(bus.busy), 0);
            if (k > 0) chk("b2b_wr", 32'({bus.mem_cs, bus.mem_we, bus.mem_address}), 32'hC00 | 32'(10'h020 + 10'(k - 1)));
            @(negedge clk);
            chk("b2b_busy_wr", 32'({bus.busy, bus.cmd_ready, bus.wr_ready}), 32'h5);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        bus.wr_valid  = 1'b0;
        chk("b2b_busy_end", 32'(bus.busy), 0);
        chk("b2b_wr_last", 32'({bus.mem_cs, bus.mem_we, bus.mem_address}), 32'hC22);
        @(negedge clk);
        chk("b2b_log", 32'({wlog_d[wlog_d.size() - 3], wlog_d[wlog_d.size() - 1]}), 32'h55505552);
        chk("b2b_idle", 32'({bus.mem_cs, bus.busy, bus.cmd_ready}), 32'h1);

        chk("contention", 32'(conflicts), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
